// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, parity
// type codes, line levels and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;

  // data_xor is the XOR of all data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic typ);
    return (typ == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the TX data phase. Bit 0 of the shift
// register is always the next data bit to go on the line.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clr,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ser_bit,
  output logic                  last_bit
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
    if (gi == DATA_WIDTH - 1) begin : g_top
      assign shift_next[gi] = load ? din[gi] : (shift ? 1'b0 : shift_reg[gi]);
    end else begin : g_mid
      assign shift_next[gi] = load ? din[gi] : (shift ? shift_reg[gi+1] : shift_reg[gi]);
    end
  end

  // Clear has priority so the shift issued while leaving START leaves the count at 0.
  always_comb begin
    cnt_next = cnt_reg;
    if (load || clr) begin
      cnt_next = '0;
    end else if (shift) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign ser_bit  = shift_reg[0];
  assign last_bit = (cnt_reg == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, stop bit.
// Define UART_TX_STOP2_EN to append a second stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_t state_reg, state_next;
  logic      tx_reg, tx_next;
  logic      busy_reg, busy_next;
  logic      par_en_reg;
  logic      parity_reg;
  logic      accept;
  logic      load, clr, shift;
  logic      ser_bit, last_bit;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clr      (clr),
    .shift    (shift),
    .din      (p_data),
    .ser_bit  (ser_bit),
    .last_bit (last_bit)
  );

  // tx_next/busy_next are the line values for the cycle after this edge.
  always_comb begin
    state_next = state_reg;
    tx_next    = LINE_IDLE;
    busy_next  = 1'b1;
    accept     = 1'b0;
    load       = 1'b0;
    clr        = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (data_valid) begin
          accept     = 1'b1;
          load       = 1'b1;
          state_next = START;
          tx_next    = LINE_START;
          busy_next  = 1'b1;
        end
      end
      START: begin
        state_next = DATA;
        tx_next    = ser_bit;
        shift      = 1'b1;
        clr        = 1'b1;
      end
      DATA: begin
        if (last_bit) begin
          if (par_en_reg) begin
            state_next = PARITY;
            tx_next    = parity_reg;
          end else begin
            state_next = STOP;
            tx_next    = LINE_STOP;
          end
        end else begin
          tx_next = ser_bit;
          shift   = 1'b1;
        end
      end
      PARITY: begin
        state_next = STOP;
        tx_next    = LINE_STOP;
      end
`ifdef UART_TX_STOP2_EN
      STOP: begin
        state_next = STOP2;
        tx_next    = LINE_STOP;
      end
      STOP2: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
`else
      STOP: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
`endif
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      tx_reg    <= LINE_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
    end
  end

  // Parity is fixed at acceptance so later par_en/par_typ changes cannot affect the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_reg <= 1'b0;
      parity_reg <= 1'b0;
    end else if (accept) begin
      par_en_reg <= par_en;
      parity_reg <= parity_bit(^p_data, par_typ);
    end
  end

  assign tx_out = tx_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level queue model checked every cycle, plus
// literal frame patterns for the directed cases.
module tb_uart_tx_frame;

  localparam int W = 8;
`ifdef UART_TX_STOP2_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         tx_out;
  logic         busy;

  int total = 0;
  int bad = 0;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: a frame is a list of line bits; it is built when a request meets an idle line.
  bit   frame_q[$];
  logic exp_tx = 1'b1;
  logic exp_busy = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && data_valid) begin
        bit pb;
        frame_q.push_back(1'b0);
        for (int i = 0; i < W; i++) frame_q.push_back(p_data[i]);
        if (par_en) begin
          pb = (($countones(p_data) % 2) == 1);
          if (par_typ) pb = !pb;
          frame_q.push_back(pb);
        end
        for (int i = 0; i < N_STOP; i++) frame_q.push_back(1'b1);
      end
      if (frame_q.size() > 0) begin
        exp_tx   = frame_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    total += 2;
    if (tx_out !== exp_tx) begin
      bad++;
      $display("FAIL cyc_tx t=%0t got=%b want=%b", $time, tx_out, exp_tx);
    end
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, busy, exp_busy);
    end
  end

  // Frame capture for literal checks: tx_out bits while busy, oldest bit in the MSB.
  logic [15:0] cap_word = '0;
  int          cap_len = 0;
  logic        prev_busy = 1'b0;
  int          idle_run = 0;
  int          last_gap = 0;
  logic [15:0] done_w[$];
  int          done_l[$];

  always @(negedge clk) begin
    if (!rst) begin
      cap_word  = '0;
      cap_len   = 0;
      prev_busy = 1'b0;
      idle_run  = 0;
    end else begin
      if (busy) begin
        if (!prev_busy) last_gap = idle_run;
        cap_word = {cap_word[14:0], tx_out};
        cap_len++;
        idle_run = 0;
      end else begin
        if (prev_busy) begin
          done_w.push_back(cap_word);
          done_l.push_back(cap_len);
          cap_word = '0;
          cap_len  = 0;
        end
        idle_run++;
      end
      prev_busy = busy;
    end
  end

  task automatic check_frame(input logic [15:0] lit, input int len, input string name);
    logic [15:0] want_w;
    int          want_l;
    logic [15:0] got_w;
    int          got_l;
    int          k;
    want_w = lit;
    want_l = len;
    if (N_STOP == 2) begin
      want_w = {lit[14:0], 1'b1};
      want_l = len + 1;
    end
    k = 0;
    while (done_w.size() == 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (done_w.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=no_frame want=frame_within_60_cycles", name);
      return;
    end
    got_w = done_w.pop_front();
    got_l = done_l.pop_front();
    total += 2;
    if (got_l != want_l) begin
      bad++;
      $display("FAIL %s_len got=%0d want=%0d", name, got_l, want_l);
    end
    if (got_w != want_w) begin
      bad++;
      $display("FAIL %s_bits got=%b want=%b", name, got_w, want_w);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    @(posedge clk);
    #1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    p_data     = ~d;
    par_en     = ~pe;
    par_typ    = ~pt;
  endtask

  task automatic check_bit(input logic got, input logic want, input string name);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_bit(tx_out, 1'b1, "reset_tx");
    check_bit(busy, 1'b0, "reset_busy");
    rst = 1'b1;
    repeat (20) @(posedge clk);
    total++;
    if (done_w.size() != 0 || cap_len != 0) begin
      bad++;
      $display("FAIL idle_activity got=%0d want=0", done_w.size() + cap_len);
    end

    send(8'hA5, 1'b1, 1'b0);
    check_frame(16'b01010010101, 11, "a5_even");
    send(8'h01, 1'b1, 1'b1);
    check_frame(16'b01000000001, 11, "01_odd");
    send(8'h01, 1'b1, 1'b0);
    check_frame(16'b01000000011, 11, "01_even");

    // Back-to-back with data_valid held and p_data changed after acceptance.
    @(posedge clk);
    #1;
    p_data     = 8'h3C;
    par_en     = 1'b0;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    p_data = 8'hFF;
    check_frame(16'b0001111001, 10, "3c_b2b");
    #1;
    data_valid = 1'b0;
    check_frame(16'b0111111111, 10, "ff_b2b");
    total++;
    if (last_gap != 1) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=1", last_gap);
    end

    // Abort during data bit 3 of 0xA5 (bit value 0).
    @(posedge clk);
    #1;
    p_data     = 8'hA5;
    par_en     = 1'b0;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_bit(tx_out, 1'b0, "pre_abort_tx");
    check_bit(busy, 1'b1, "pre_abort_busy");
    #1;
    rst = 1'b0;
    #1;
    check_bit(tx_out, 1'b1, "abort_tx");
    check_bit(busy, 1'b0, "abort_busy");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    done_w.delete();
    done_l.delete();
    send(8'h55, 1'b0, 1'b0);
    check_frame(16'b0101010101, 10, "55_after_rst");

    send(8'h00, 1'b0, 1'b0);
    check_frame(16'b0000000001, 10, "00_stop");

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter that converts a parallel byte into a serial frame: start bit, LSB-first data, optional parity, stop bit.
- It is the transmit-side counterpart of the receiver's oversampled data-sampling path.
- clk is the bit clock: one clk period equals one bit time, so it runs from the divided TX clock domain.
- Upstream (the system controller or TX FIFO read side) hands over bytes with a valid/busy handshake.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (minimum 5).

Ports:
- clk  in  1  TX bit clock.
- rst  in  1  reset, asynchronous, active-low.
- p_data  in  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
- data_valid  in  1  request to send p_data.
- par_en  in  1  1 = parity bit included in the frame.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- tx_out  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line.

Behaviour:
- Reset values: tx_out=1, busy=0, state=IDLE, bit counter=0, shift register=0. Reset is asynchronous, so asserting rst mid-frame aborts the frame immediately and the line returns high.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - A byte is accepted only when state=IDLE and data_valid=1 at a clk edge.
  - On acceptance, p_data is latched and par_en/par_typ are captured for the whole frame. Later input changes have no effect on the current frame.
  - data_valid while busy=1 is ignored; it is not queued.
- Transitions:
  - IDLE goes to START on acceptance.
  - START goes to DATA.
  - DATA goes to PARITY after DATA_WIDTH bits if captured par_en=1; otherwise it goes to STOP.
  - PARITY goes to STOP.
  - STOP goes to IDLE.
- Outputs are registered. With acceptance at edge N:
  - tx_out=0 (start bit) and busy=1 during cycle N+1.
  - data bit i (LSB first) is driven during cycle N+2+i.
  - the parity bit, if enabled, follows the last data bit.
  - stop=1 is driven for one cycle.
- After the stop bit, busy=0 in the same cycle that state returns to IDLE.
- Frame length is 10 cycles (no parity) or 11 cycles (parity) for DATA_WIDTH=8.
- Back-to-back transfers: if data_valid is held high, the next frame's start bit follows after exactly one IDLE cycle with tx_out=1.
- Parity is computed from the latched byte: even gives XOR of all bits, odd gives its inverse.
- The bit counter is sized $clog2(DATA_WIDTH) bits and is cleared on entry to DATA. The DATA-to-next-state transition fires when counter == DATA_WIDTH-1; the counter never wraps mid-frame.
- tx_out in IDLE is constantly 1; busy in IDLE is constantly 0.

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- When defined, a STOP2 state is inserted after STOP, driving tx_out=1 for a second bit time. busy stays high through STOP2, and frame length grows by 1 cycle.
- When undefined, the frame has a single stop bit and the STOP2 state and its logic are absent.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef for the TX FSM (IDLE=0, START, DATA, PARITY, STOP, STOP2).
  - parity-type constants PAR_EVEN=0, PAR_ODD=1.
  - start/stop line-level constants.
- One natural sub-module, uart_tx_serializer: the shift register plus bit counter, with load/shift controls and a last_bit flag. The FSM and parity logic stay in uart_tx_frame.

Test Plan:
- Reset, then idle for 20 cycles -> tx_out=1 and busy=0 throughout; data_valid=0.
- p_data=0xA5, par_en=1, par_typ=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0). busy is high for exactly 11 cycles.
- p_data=0x01, par_en=1, par_typ=1 -> parity bit 0; same byte with par_typ=0 -> parity bit 1.
- p_data=0x3C, par_en=0, data_valid held high, p_data changed to 0xFF on the cycle after acceptance:
  - first frame serializes 0x3C (0,0,0,1,1,1,1,0,0,1).
  - one idle-high cycle follows.
  - the second frame serializes 0xFF.
- Assert rst low at the 4th data bit of a frame -> tx_out=1 and busy=0 asynchronously. After release, a new byte 0x55 transmits correctly.
- With UART_TX_STOP2_EN defined, p_data=0x00, par_en=0 -> 11-cycle frame ending 1,1. busy stays high through both stop bits.
